mac_stream_ctrl: RTL
====================

// Module: mac_stream_ctrl
// PURPOSE
// - Valid/ready streaming shell around the 2-stage MAC pipeline, which has no stall input.
// - Drives MAC operands and control from an upstream request stream and tracks in-flight ops with a valid/tag shift register.
// - Captures MAC results into a FWFT result FIFO. Credit-based issue guarantees no result is ever dropped under downstream backpressure.
// PARAMETERS
// - MAC_LAT     2  MAC input-to-output latency in clock edges; must match the MAC pipeline depth.
// - FIFO_DEPTH  4  result FIFO entries; power of 2, >= MAC_LAT.
// - TAG_W       4  width of the opaque request tag carried alongside each op.
// PORTS
// - clk        in   1      clock; all logic on posedge.
// - rst_n      in   1      asynchronous active-low reset.
// - in_valid   in   1      upstream request valid.
// - in_ready   out  1      upstream may issue this cycle.
// - in_mode    in   2      00=FP32, 01=FP16, 10=mixed.
// - in_rm      in   3      rounding mode.
// - in_a/b/c   in   32     operands; FP16 operands in [15:0].
// - in_tag     in   TAG_W  request tag.
// - mac_fp_mode out 2      to MAC fp_mode.
// - mac_rm     out  3      to MAC rm_i.
// - mac_a/b/c  out  32     to MAC A_i/B_i/C_i.
// - mac_r32    in   32     from MAC R32_o.
// - mac_r16    in   16     from MAC R16_o.
// - mac_flags  in   5      from MAC flags_o: [4]NV [3]OF [2]UF [1]NX [0]rsvd.
// - out_valid  out  1      result available at FIFO head.
// - out_ready  in   1      downstream accepts the head.
// - out_r32 / out_r16 / out_flags / out_tag  out  32/16/5/TAG_W  head entry fields.
// - busy       out  1      any op in flight or FIFO not empty.
// BEHAVIOUR
// - Reset (async): shift register, FIFO pointers and count cleared. in_ready=1, out_valid=0, busy=0. out_* data=0, credits=FIFO_DEPTH.
// - Issue (fire):
//   - fire = in_valid & in_ready.
//   - mac_* are combinational copies of in_*, gated to 0 when !fire so idle cycles present zero operands.
// - Credits:
//   - credits = FIFO_DEPTH - fifo_count - inflight; in_ready = (credits != 0).
//   - Counter decrements on fire and increments on FIFO pop. Simultaneous fire and pop leave it unchanged.
// - Tracking:
//   - vld_sr/tag_sr/mode_sr are MAC_LAT deep and shift every cycle; stage 0 loads {fire, in_tag, in_mode}.
//   - When vld_sr[MAC_LAT-1]=1, {mac_r32, mac_r16, mac_flags, tag} is pushed into the FIFO on that edge.
//   - For mode != 01, the stored r16 is forced to 0.
// - Latency: op accepted in cycle 0 -> out_valid=1 in cycle MAC_LAT+1 (3 by default), provided the FIFO was empty.
// - FIFO:
//   - FWFT; out_* reflect the head while out_valid=1 and are held stable until out_ready.
//   - Pop = out_valid & out_ready.
//   - Push and pop in the same cycle are both honoured and the count is unchanged; pointers wrap modulo FIFO_DEPTH.
//   - A push into a full FIFO is impossible by construction; an assertion fires if it occurs.
// - Ordering: results leave in issue order; tags are never reordered.
// - Mid-operation reset: in-flight ops and FIFO contents are discarded with no partial output. The MAC pipeline is reset on the same rst_n.
// - busy = |vld_sr | (fifo_count != 0).
// CONFIGURATION
// - MAC_STREAM_STATS_EN defined: adds outputs stat_issued[31:0] (fire count) and stat_nv[15:0] (count of popped results with flags[4]=1).
//   - Both counters saturate at all-ones and clear on reset.
// - MAC_STREAM_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
// - FP32 single op, out_ready=1: A=3F800000 B=40000000 C=3F000000 tag=5 in cycle 0 -> cycle 3: out_valid=1, out_r32=40200000, out_tag=5, flags=0.
// - FP16 op: mode=01, A=3C00 B=4000 C=3800 -> out_r16=4100, out_r32=40200000. Same op with mode=10 -> out_r16=0000.
// - Backpressure: out_ready=0, in_valid held 1 with tags 0..7 -> exactly 4 accepted, then in_ready=0. Raise out_ready -> tags 0,1,2,3 pop in order, and issue resumes one credit per pop.
// - Invalid op: A=7F800000 (Inf) B=00000000 C=0 -> out_r32=7FC00000, out_flags[4]=1. With MAC_STREAM_STATS_EN, stat_nv increments by 1 on pop.
// - Simultaneous push/pop: stream 16 ops with out_ready=1 and in_valid=1 throughout -> in_ready never drops after the first cycle, 16 results in order, no gaps after the first result.
// - Reset mid-flight: issue 3 ops, assert rst_n=0 one cycle later -> out_valid=0, busy=0, in_ready=1 immediately; no stale result appears after release.

Source files
------------

// File: rtl/mac_stream_ctrl_if.sv
// mac_stream_ctrl_if: upstream request stream and downstream result stream of the MAC shell
interface mac_stream_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [2:0]       in_rm;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_c;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_r32;
  logic [15:0]      out_r16;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_mode, in_rm, in_a, in_b, in_c, in_tag, out_ready,
    input  in_ready, out_valid, out_r32, out_r16, out_flags, out_tag
  );
  modport slave (
    input  in_valid, in_mode, in_rm, in_a, in_b, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_r32, out_r16, out_flags, out_tag
  );
endinterface

// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl: valid/ready shell around a stall-free MAC pipeline; credit-based issue into a FWFT result FIFO; define MAC_STREAM_STATS_EN for stat_issued/stat_nv counters
module mac_stream_ctrl #(
  parameter int MAC_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_stream_ctrl_if.slave bus,
  output logic [1:0]       mac_fp_mode,
  output logic [2:0]       mac_rm,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  input  logic [31:0]      mac_r32,
  input  logic [15:0]      mac_r16,
  input  logic [4:0]       mac_flags,
  output logic             busy
`ifdef MAC_STREAM_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [15:0]      stat_nv
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  logic             fire, push, pop;
  logic [MAC_LAT-1:0] vld_sr;
  logic [TAG_W-1:0] tag_sr [MAC_LAT];
  logic [1:0]       mode_sr [MAC_LAT];
  logic [CW-1:0]    credits, count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [31:0]      r32_mem [FIFO_DEPTH];
  logic [15:0]      r16_mem [FIFO_DEPTH];
  logic [4:0]       flags_mem [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
  assign fire          = bus.in_valid & bus.in_ready;
  assign bus.in_ready  = credits != '0;
  assign push          = vld_sr[MAC_LAT-1];
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = count != '0;
  assign busy          = |vld_sr | bus.out_valid;
  assign mac_fp_mode   = fire ? bus.in_mode : '0;
  assign mac_rm        = fire ? bus.in_rm : '0;
  assign mac_a         = fire ? bus.in_a : '0;
  assign mac_b         = fire ? bus.in_b : '0;
  assign mac_c         = fire ? bus.in_c : '0;
  assign bus.out_r32   = bus.out_valid ? r32_mem[rd_ptr] : '0;
  assign bus.out_r16   = bus.out_valid ? r16_mem[rd_ptr] : '0;
  assign bus.out_flags = bus.out_valid ? flags_mem[rd_ptr] : '0;
  assign bus.out_tag   = bus.out_valid ? tag_mem[rd_ptr] : '0;
  // in-flight tracker mirroring the MAC pipeline: valid, tag and mode ride alongside each op
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_sr  <= '0;
      tag_sr  <= '{default: '0};
      mode_sr <= '{default: '0};
    end else begin
      vld_sr[0]  <= fire;
      tag_sr[0]  <= bus.in_tag;
      mode_sr[0] <= bus.in_mode;
      for (int i = 1; i < MAC_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        tag_sr[i]  <= tag_sr[i-1];
        mode_sr[i] <= mode_sr[i-1];
      end
    end
  // credits cover FIFO slots plus ops still in the MAC, so every result has a guaranteed slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) credits <= CW'(FIFO_DEPTH);
    else credits <= credits - CW'(fire) + CW'(pop);
  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // FIFO storage; r16 is only meaningful for pure FP16 ops
  always_ff @(posedge clk)
    if (push) begin
      r32_mem[wr_ptr]   <= mac_r32;
      r16_mem[wr_ptr]   <= mode_sr[MAC_LAT-1] == 2'b01 ? mac_r16 : '0;
      flags_mem[wr_ptr] <= mac_flags;
      tag_mem[wr_ptr]   <= tag_sr[MAC_LAT-1];
    end
`ifdef MAC_STREAM_STATS_EN
  // saturating issue and invalid-result counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issued <= '0;
      stat_nv     <= '0;
    end else begin
      if (fire && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
      if (pop && bus.out_flags[4] && stat_nv != '1) stat_nv <= stat_nv + 16'd1;
    end
`endif
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CW'(FIFO_DEPTH)));
endmodule
